// File: rtl/game_master_ctrl.sv
// Master controller for the linked-state-machine maze game.
// Sequences IDLE -> PLAY -> WIN/LOSE -> IDLE, forwards gated button
// presses to the maze sub-SM, runs the per-game countdown and keeps a
// saturating count of games won.
module game_master_ctrl #(
    parameter int TICK_DIV   = 100000000,
    parameter int TIME_LIMIT = 60
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       BTNU,
    input  logic       BTNL,
    input  logic       BTNC,
    input  logic       BTNR,
    input  logic [3:0] MAZE_STATE,
    input  logic [3:0] MAZE_DEC,
    output logic [1:0] MASTER_STATE,
    output logic       SUB_RESET,
    output logic       BTNL_P,
    output logic       BTNC_P,
    output logic       BTNR_P,
    output logic [3:0] DEC_OUT,
    output logic [7:0] SECS_LEFT,
    output logic [3:0] WIN_COUNT,
    output logic       LED_WIN,
    output logic       LED_LOSE
);

    // A one-cycle divider still needs a 1-bit counter to exist.
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_PLAY = 2'b01,
        S_WIN  = 2'b10,
        S_LOSE = 2'b11
    } state_t;

    state_t        state;
    logic [TW-1:0] tick;
    logic [7:0]    secs_left;
    logic [3:0]    win_count;
    logic [3:0]    btn_hist;   // {U, L, C, R} levels from the previous cycle
    logic [3:0]    btn_now;
    logic [3:0]    btn_rise;
    logic          tick_wrap;
    logic          btnl_p;
    logic          btnc_p;
    logic          btnr_p;

    assign btn_now   = {BTNU, BTNL, BTNC, BTNR};
    assign btn_rise  = btn_now & ~btn_hist;
    assign tick_wrap = (tick == TICK_LAST);

    // State machine, countdown, win counter, button history and gated pulses.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            tick      <= '0;
            secs_left <= 8'd0;
            win_count <= 4'd0;
            btn_hist  <= 4'b0000;
            btnl_p    <= 1'b0;
            btnc_p    <= 1'b0;
            btnr_p    <= 1'b0;
        end else begin
            btn_hist <= btn_now;
            // Presses reach the maze only while a game is actually running.
            btnl_p   <= btn_rise[2] && (state == S_PLAY);
            btnc_p   <= btn_rise[1] && (state == S_PLAY);
            btnr_p   <= btn_rise[0] && (state == S_PLAY);

            case (state)
                S_IDLE: begin
                    tick <= '0;
                    if (btn_rise[3]) begin
                        state     <= S_PLAY;
                        secs_left <= 8'(TIME_LIMIT);
                    end
                end
                S_PLAY: begin
                    if (tick_wrap) begin
                        tick <= '0;
                        if (secs_left != 8'd0)
                            secs_left <= secs_left - 8'd1;
                    end else begin
                        tick <= tick + TW'(1);
                    end
                    // Finishing the maze beats a timeout on the same edge.
                    if (MAZE_STATE == 4'hF) begin
                        state <= S_WIN;
                        tick  <= '0;
                        if (win_count != 4'hF)
                            win_count <= win_count + 4'd1;
                    end else if (tick_wrap && secs_left == 8'd1) begin
                        state <= S_LOSE;
                        tick  <= '0;
                    end
                end
                S_WIN, S_LOSE: begin
                    tick <= '0;
                    if (btn_rise[3])
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decoded from the state register only (maze digit passes through in PLAY).
    always_comb begin
        DEC_OUT = 4'h0;
        case (state)
            S_IDLE: DEC_OUT = 4'h0;
            S_PLAY: DEC_OUT = MAZE_DEC;
            S_WIN:  DEC_OUT = 4'hA;
            S_LOSE: DEC_OUT = 4'hE;
            default: DEC_OUT = 4'h0;
        endcase
    end

    assign MASTER_STATE = state;
    assign SUB_RESET    = (state == S_IDLE);
    assign LED_WIN      = (state == S_WIN);
    assign LED_LOSE     = (state == S_LOSE);
    assign SECS_LEFT    = secs_left;
    assign WIN_COUNT    = win_count;
    assign BTNL_P       = btnl_p;
    assign BTNC_P       = btnc_p;
    assign BTNR_P       = btnr_p;

endmodule

// File: tb/tb_game_master_ctrl.sv
// Bench for game_master_ctrl with TICK_DIV=4, TIME_LIMIT=3: directed
// scenarios with literal expectations followed by random stimulus, all
// checked every cycle against a behavioural game model.
module tb_game_master_ctrl;

    localparam int TD = 4;
    localparam int TL = 3;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       BTNU = 1'b0;
    logic       BTNL = 1'b0;
    logic       BTNC = 1'b0;
    logic       BTNR = 1'b0;
    logic [3:0] MAZE_STATE = 4'h0;
    logic [3:0] MAZE_DEC = 4'h0;
    logic [1:0] MASTER_STATE;
    logic       SUB_RESET;
    logic       BTNL_P;
    logic       BTNC_P;
    logic       BTNR_P;
    logic [3:0] DEC_OUT;
    logic [7:0] SECS_LEFT;
    logic [3:0] WIN_COUNT;
    logic       LED_WIN;
    logic       LED_LOSE;

    game_master_ctrl #(.TICK_DIV(TD), .TIME_LIMIT(TL)) dut (
        .CLK(CLK), .RESET(RESET),
        .BTNU(BTNU), .BTNL(BTNL), .BTNC(BTNC), .BTNR(BTNR),
        .MAZE_STATE(MAZE_STATE), .MAZE_DEC(MAZE_DEC),
        .MASTER_STATE(MASTER_STATE), .SUB_RESET(SUB_RESET),
        .BTNL_P(BTNL_P), .BTNC_P(BTNC_P), .BTNR_P(BTNR_P),
        .DEC_OUT(DEC_OUT), .SECS_LEFT(SECS_LEFT), .WIN_COUNT(WIN_COUNT),
        .LED_WIN(LED_WIN), .LED_LOSE(LED_LOSE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: game phase, cycles elapsed in the current game,
    // wins so far, previous button levels and the forwarded presses.
    int   m_phase;     // 0 idle, 1 play, 2 win, 3 lose
    int   m_elapsed;
    int   m_secs;
    int   m_wins;
    bit   m_pu, m_pl, m_pc, m_pr;
    bit   m_ol, m_oc, m_or;

    always @(posedge CLK) begin : model
        bit ru;
        int e;
        if (RESET) begin
            m_phase <= 0; m_elapsed <= 0; m_secs <= 0; m_wins <= 0;
            m_pu <= 0; m_pl <= 0; m_pc <= 0; m_pr <= 0;
            m_ol <= 0; m_oc <= 0; m_or <= 0;
        end else begin
            ru = BTNU && !m_pu;
            m_ol <= (BTNL && !m_pl) && (m_phase == 1);
            m_oc <= (BTNC && !m_pc) && (m_phase == 1);
            m_or <= (BTNR && !m_pr) && (m_phase == 1);
            m_pu <= BTNU; m_pl <= BTNL; m_pc <= BTNC; m_pr <= BTNR;
            case (m_phase)
                0: if (ru) begin m_phase <= 1; m_elapsed <= 0; m_secs <= TL; end
                1: begin
                    e = m_elapsed + 1;
                    m_elapsed <= e;
                    m_secs <= TL - e / TD;
                    if (MAZE_STATE == 4'hF) begin
                        m_phase <= 2;
                        m_wins <= (m_wins < 15) ? m_wins + 1 : 15;
                    end else if (e == TL * TD) begin
                        m_phase <= 3;
                    end
                end
                default: if (ru) m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        int exp_dec;
        if (chk_en) begin
            exp_dec = (m_phase == 0) ? 0 : (m_phase == 1) ? int'(MAZE_DEC) :
                      (m_phase == 2) ? 10 : 14;
            check("state", int'(MASTER_STATE), m_phase);
            check("sub_reset", int'(SUB_RESET), int'(m_phase == 0));
            check("dec_out", int'(DEC_OUT), exp_dec);
            check("secs_left", int'(SECS_LEFT), m_secs);
            check("win_count", int'(WIN_COUNT), m_wins);
            check("led_win", int'(LED_WIN), int'(m_phase == 2));
            check("led_lose", int'(LED_LOSE), int'(m_phase == 3));
            check("btnl_p", int'(BTNL_P), int'(m_ol));
            check("btnc_p", int'(BTNC_P), int'(m_oc));
            check("btnr_p", int'(BTNR_P), int'(m_or));
        end
    end

    // Inputs change just after the falling edge, so both edges see them stable.
    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    task automatic press_u();
        BTNU = 1'b1; step();
        BTNU = 1'b0; step();
    endtask

    initial begin
        // 1: reset
        RESET = 1'b1;
        step(); step();
        chk_en = 1'b1;
        check("rst_state", int'(MASTER_STATE), 0);
        check("rst_sub_reset", int'(SUB_RESET), 1);
        check("rst_dec", int'(DEC_OUT), 0);
        check("rst_secs", int'(SECS_LEFT), 0);
        check("rst_wins", int'(WIN_COUNT), 0);
        check("rst_pulses", int'({BTNL_P, BTNC_P, BTNR_P}), 0);
        RESET = 1'b0;
        step();

        // 2: start a game with BTNU held
        BTNU = 1'b1; step();
        check("start_state", int'(MASTER_STATE), 1);
        check("start_secs", int'(SECS_LEFT), 3);
        check("start_sub_reset", int'(SUB_RESET), 0);
        repeat (4) step();
        check("hold_state", int'(MASTER_STATE), 1);
        check("hold_secs", int'(SECS_LEFT), 2);
        BTNU = 1'b0;

        // 3: BTNC held in PLAY gives one pulse
        BTNC = 1'b1; step();
        check("btnc_first", int'(BTNC_P), 1);
        step();
        check("btnc_second", int'(BTNC_P), 0);
        repeat (3) step();
        BTNC = 1'b0;
        for (int i = 0; i < 20 && MASTER_STATE != 2'b11; i++) step();
        check("reach_lose", int'(MASTER_STATE), 3);
        press_u();
        check("back_idle", int'(SUB_RESET), 1);
        BTNC = 1'b1; step();
        check("btnc_idle", int'(BTNC_P), 0);
        BTNC = 1'b0; step();

        // 4: timeout exactly TL*TD edges after entry
        BTNU = 1'b1; step();
        BTNU = 1'b0;
        repeat (11) step();
        check("pre_lose_state", int'(MASTER_STATE), 1);
        check("pre_lose_secs", int'(SECS_LEFT), 1);
        step();
        check("lose_state", int'(MASTER_STATE), 3);
        check("lose_secs", int'(SECS_LEFT), 0);
        check("lose_dec", int'(DEC_OUT), 14);
        check("lose_led", int'(LED_LOSE), 1);
        press_u();

        // 5: maze finished on the final tick wins
        BTNU = 1'b1; step();
        BTNU = 1'b0;
        repeat (11) step();
        MAZE_STATE = 4'hF; step();
        MAZE_STATE = 4'h0;
        check("win_state", int'(MASTER_STATE), 2);
        check("win_count1", int'(WIN_COUNT), 1);
        check("win_dec", int'(DEC_OUT), 10);
        press_u();
        check("win_to_idle", int'(SUB_RESET), 1);

        // 6: saturate the win counter, then reset mid-game
        for (int g = 0; g < 15; g++) begin
            press_u();
            MAZE_STATE = 4'hF; step();
            MAZE_STATE = 4'h0;
            press_u();
        end
        check("win_sat", int'(WIN_COUNT), 15);
        press_u();
        check("play_before_rst", int'(MASTER_STATE), 1);
        RESET = 1'b1; step();
        RESET = 1'b0;
        check("rst_mid_state", int'(MASTER_STATE), 0);
        check("rst_mid_wins", int'(WIN_COUNT), 0);

        // Random phase against the model
        for (int i = 0; i < 4000; i++) begin
            BTNU = ($urandom % 6) == 0;
            BTNL = ($urandom % 3) == 0;
            BTNC = ($urandom % 3) == 0;
            BTNR = ($urandom % 3) == 0;
            MAZE_STATE = (($urandom % 20) == 0) ? 4'hF : 4'($urandom % 15);
            MAZE_DEC = 4'($urandom);
            RESET = ($urandom % 300) == 0;
            step();
        end
        RESET = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
